imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares one single-port instruction memory between the CPU fetch port (read) and the host
//  program loader (write). Fixed fetch priority, with a starvation counter that forces a
//  loader grant. Sits between fetch stage / loader and the imem array (1-cycle sync read).
// PARAMETERS
//  ADDR_W       16  address width (word addressed)
//  DATA_W       32  instruction width
//  DEPTH        64  valid words; addresses >= DEPTH are out of range
//  STARVE_LIMIT 4   consecutive denied loader cycles before loader is forced through
// PORTS
//  clk          in   1       clock
//  rst          in   1       asynchronous, active-high reset
//  f_req        in   1       fetch read request
//  f_addr       in   ADDR_W  fetch address
//  f_gnt        out  1       fetch accepted this cycle
//  f_rvalid     out  1       fetch data valid (1 cycle after f_gnt)
//  f_rdata      out  DATA_W  fetch data
//  l_req        in   1       loader write request
//  l_addr       in   ADDR_W  loader address
//  l_wdata      in   DATA_W  loader data
//  l_gnt        out  1       loader write accepted/committed this cycle
//  m_addr       out  ADDR_W  memory address
//  m_we         out  1       memory write enable
//  m_wdata      out  DATA_W  memory write data
//  m_rdata      in   DATA_W  memory read data (valid cycle after address)
//  starved      out  1       starvation override active this cycle
// BEHAVIOUR
//  - Reset: f_gnt=f_rvalid=l_gnt=m_we=starved=0; f_rdata=0; m_addr=0; starve_cnt=0.
//  - Grant (combinational per cycle, from req + registered starve_cnt):
//    l_req & (~f_req | starve_cnt==STARVE_LIMIT) -> loader; else f_req -> fetch; else none.
//  - Fetch grant cycle N: m_addr=f_addr, m_we=0. Cycle N+1: f_rvalid=1, f_rdata=m_rdata
//    (registered). Back-to-back fetch grants give one rvalid per cycle; throughput 1/clk.
//  - Loader grant: m_addr=l_addr, m_wdata=l_wdata, m_we=1 same cycle; write commits at edge.
//  - starve_cnt: +1 when l_req & ~l_gnt (saturates at STARVE_LIMIT); cleared on l_gnt or ~l_req.
//    starved = (starve_cnt==STARVE_LIMIT) & l_req.
//  - Simultaneous f_req & l_req, cnt<LIMIT: fetch wins; loader holds req/addr/data stable.
//  - Read after write to same addr: fetch granted cycle after l_gnt sees new data.
//  - Idle cycles: m_we=0, m_addr holds last value, f_rvalid=0 next cycle.
//  - Reset mid-operation: pending rvalid dropped (no rvalid after reset); counter cleared.
//  - f_rdata holds last value when f_rvalid=0.
// CONFIGURATION
//  IMEM_BOUNDS_CHECK_EN defined: fetch addr >= DEPTH still granted, f_rdata=0 with
//    f_rvalid=1; loader addr >= DEPTH granted but m_we forced 0 (write dropped).
//  Undefined: addresses passed to memory unchecked; out-of-range behaviour is the array's.
// STRUCTURE
//  Package imem_arb_pkg: typedef enum logic[1:0] {GNT_NONE, GNT_FETCH, GNT_LOAD} gnt_t;
//    ADDR_W/DATA_W default constants.
//  Sub-module imem_starve_counter (req, gnt -> cnt, at_limit), parameterised STARVE_LIMIT.
//  Top: grant decode, mem mux, 1-stage rvalid/rdata register with gnt_t pipeline tag.
// TESTING
//  1. f_req only, addrs 0,1,2 back-to-back -> f_gnt 3 cycles, f_rvalid cycles 2-4, data=mem[0..2].
//  2. l_req only addr 5 data 0xDEADBEEF -> l_gnt & m_we same cycle; fetch 5 next -> 0xDEADBEEF.
//  3. f_req and l_req held high -> fetch granted 4 cycles, 5th cycle l_gnt=1, starved=1, then
//     fetch resumes; repeats every 5 cycles.
//  4. rst asserted cycle after f_gnt -> no f_rvalid, all outputs 0, starve_cnt 0.
//  5. IMEM_BOUNDS_CHECK_EN: fetch addr 64 -> f_rvalid=1 f_rdata=0; load addr 70 -> l_gnt=1, m_we=0.
//  6. l_req drop at cnt=3 then reassert -> counter restarted from 0 (no early override).

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Build option: define IMEM_BOUNDS_CHECK_EN to enable address range checking.
// Contains the grant tag type and a range-check helper.
package imem_arb_pkg;

    localparam int IMEM_ADDR_W = 16;
    localparam int IMEM_DATA_W = 32;

    // Which requester owns the memory port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_LOAD  = 2'd2
    } gnt_t;

    // True when a word address falls inside the populated part of the array.
    function automatic logic addr_in_range(input logic [IMEM_ADDR_W-1:0] addr,
                                           input int unsigned depth);
        return (32'(addr) < depth);
    endfunction

endpackage

// File: rtl/imem_starve_counter.sv
// Counts consecutive cycles a loader request is denied, saturating at STARVE_LIMIT.
// Latency: count updates at the clock edge; at_limit is a decode of the registered count.
// Backpressure: none; observes req/gnt only. Cleared on grant or when the request drops.
module imem_starve_counter #(
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             gnt,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart whenever the loader is served or stops asking, else saturate upward.
    always_comb begin
        cnt_d = cnt_q;
        if (!req || gnt) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port imem between CPU fetch (read) and host loader (write); fetch has priority.
// Latency: grant and memory command are combinational; fetch data/rvalid appear one cycle after f_gnt.
// Backpressure: the loser of a cycle sees no grant and must hold its request; starvation forces the loader.
// Build option: IMEM_BOUNDS_CHECK_EN zeroes out-of-range fetch data and drops out-of-range writes.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W       = IMEM_ADDR_W,
    parameter int DATA_W       = IMEM_DATA_W,
    parameter int DEPTH        = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              starved
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    gnt_t              gnt;
    gnt_t              tag_q;
    gnt_t              tag_d;
    logic [ADDR_W-1:0] m_addr_q;
    logic [ADDR_W-1:0] m_addr_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic [CNT_W-1:0]  starve_cnt;
    logic              at_limit;
    logic              l_in_range;
    logic              oob_q;
    logic              oob_d;

    imem_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .req      (l_req),
        .gnt      (l_gnt),
        .cnt      (starve_cnt),
        .at_limit (at_limit)
    );

    // Grant decode: loader wins when fetch is idle or the loader has been starved long enough.
    always_comb begin
        gnt = GNT_NONE;
        if (l_req && (!f_req || at_limit)) begin
            gnt = GNT_LOAD;
        end else if (f_req) begin
            gnt = GNT_FETCH;
        end
    end

    assign f_gnt   = (gnt == GNT_FETCH);
    assign l_gnt   = (gnt == GNT_LOAD);
    assign starved = (starve_cnt == LIMIT) && l_req;

`ifdef IMEM_BOUNDS_CHECK_EN
    assign l_in_range = addr_in_range(IMEM_ADDR_W'(l_addr), DEPTH);
    assign oob_d      = f_gnt && !addr_in_range(IMEM_ADDR_W'(f_addr), DEPTH);
`else
    assign l_in_range = 1'b1;
    assign oob_d      = 1'b0;
`endif

    // Memory command mux: the address holds its last value on idle cycles.
    always_comb begin
        m_addr_d = m_addr_q;
        case (gnt)
            GNT_LOAD:  m_addr_d = l_addr;
            GNT_FETCH: m_addr_d = f_addr;
            default:   m_addr_d = m_addr_q;
        endcase
    end

    assign m_addr  = m_addr_d;
    assign m_we    = l_gnt && l_in_range;
    assign m_wdata = l_wdata;

    // Read-return path: the tag marks the cycle whose memory output belongs to fetch;
    // the data register keeps the last returned word visible between reads.
    always_comb begin
        tag_d    = gnt;
        f_rvalid = (tag_q == GNT_FETCH);
        f_rdata  = rdata_q;
        if (f_rvalid) begin
            f_rdata = oob_q ? '0 : m_rdata;
        end
        rdata_d  = f_rdata;
    end

    // Pipeline and hold registers; reset drops any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q    <= GNT_NONE;
            oob_q    <= 1'b0;
            m_addr_q <= '0;
            rdata_q  <= '0;
        end else begin
            tag_q    <= tag_d;
            oob_q    <= oob_d;
            m_addr_q <= m_addr_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 1-cycle synchronous imem.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Memory is preloaded with 0x1000_0000 + index whenever rst is high.
module tb_imem_arbiter;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        l_req;
    logic [15:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic [15:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        starved;

    int tests;
    int fails;

    logic [31:0] mem [0:127];

    imem_arbiter #(
        .ADDR_W(16), .DATA_W(32), .DEPTH(64), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .starved(starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            m_rdata <= '0;
        end else begin
            if (m_we) mem[m_addr[6:0]] <= m_wdata;
            m_rdata <= mem[m_addr[6:0]];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        f_req;
        logic [15:0] f_addr;
        logic        l_req;
        logic [15:0] l_addr;
        logic [31:0] l_wdata;
        logic        e_fgnt;
        logic        e_lgnt;
        logic        e_we;
        logic [15:0] e_maddr;
        logic        e_rvalid;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vec [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fr, input logic [15:0] fa,
                         input logic lr, input logic [15:0] la, input logic [31:0] lw);
        @(posedge clk);
        #1;
        f_req = fr; f_addr = fa; l_req = lr; l_addr = la; l_wdata = lw;
        @(negedge clk);
    endtask

    // Arbitration checks for one cycle while both sides are (or were) requesting.
    task automatic chk_arb(input string tag, input logic exp_l, input logic exp_f,
                           input logic exp_rv);
        chk({tag, ".l_gnt"},   32'(l_gnt),    32'(exp_l));
        chk({tag, ".f_gnt"},   32'(f_gnt),    32'(exp_f));
        chk({tag, ".starved"}, 32'(starved),  32'(exp_l & f_req));
        chk({tag, ".rvalid"},  32'(f_rvalid), 32'(exp_rv));
    endtask

    logic prev_f;

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1;
        f_req = 0; f_addr = 0; l_req = 0; l_addr = 0; l_wdata = 0;

        // f_req, f_addr, l_req, l_addr, l_wdata | f_gnt, l_gnt, m_we, m_addr, rvalid, rdata
        vec[0] = '{1'b1, 16'd0, 1'b0, 16'd0, 32'h0,         1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 32'h0};
        vec[1] = '{1'b1, 16'd1, 1'b0, 16'd0, 32'h0,         1'b1, 1'b0, 1'b0, 16'd1, 1'b1, 32'h1000_0000};
        vec[2] = '{1'b1, 16'd2, 1'b0, 16'd0, 32'h0,         1'b1, 1'b0, 1'b0, 16'd2, 1'b1, 32'h1000_0001};
        vec[3] = '{1'b0, 16'd0, 1'b0, 16'd0, 32'h0,         1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 32'h1000_0002};
        vec[4] = '{1'b0, 16'd0, 1'b0, 16'd0, 32'h0,         1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 32'h1000_0002};
        vec[5] = '{1'b0, 16'd0, 1'b1, 16'd5, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 16'd5, 1'b0, 32'h1000_0002};
        vec[6] = '{1'b1, 16'd5, 1'b0, 16'd0, 32'h0,         1'b1, 1'b0, 1'b0, 16'd5, 1'b0, 32'h1000_0002};
        vec[7] = '{1'b0, 16'd0, 1'b0, 16'd0, 32'h0,         1'b0, 1'b0, 1'b0, 16'd5, 1'b1, 32'hDEAD_BEEF};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.f_gnt",    32'(f_gnt),    32'h0);
        chk("rst.l_gnt",    32'(l_gnt),    32'h0);
        chk("rst.f_rvalid", 32'(f_rvalid), 32'h0);
        chk("rst.m_we",     32'(m_we),     32'h0);
        chk("rst.starved",  32'(starved),  32'h0);
        chk("rst.f_rdata",  f_rdata,       32'h0);
        chk("rst.m_addr",   32'(m_addr),   32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back fetch, idle hold, loader write, read-after-write
        for (int i = 0; i < 8; i++) begin
            drive(vec[i].f_req, vec[i].f_addr, vec[i].l_req, vec[i].l_addr, vec[i].l_wdata);
            chk($sformatf("vec%0d.f_gnt", i),    32'(f_gnt),    32'(vec[i].e_fgnt));
            chk($sformatf("vec%0d.l_gnt", i),    32'(l_gnt),    32'(vec[i].e_lgnt));
            chk($sformatf("vec%0d.m_we", i),     32'(m_we),     32'(vec[i].e_we));
            chk($sformatf("vec%0d.m_addr", i),   32'(m_addr),   32'(vec[i].e_maddr));
            chk($sformatf("vec%0d.f_rvalid", i), 32'(f_rvalid), 32'(vec[i].e_rvalid));
            chk($sformatf("vec%0d.f_rdata", i),  f_rdata,       vec[i].e_rdata);
            if (vec[i].e_we) chk($sformatf("vec%0d.m_wdata", i), m_wdata, vec[i].l_wdata);
        end

        // Both requesting continuously: loader forced through every fifth cycle
        prev_f = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 16'd3, 1'b1, 16'd9, 32'hA5A5_A5A5);
            chk_arb($sformatf("starve%0d", k), (k % 5) == 4, (k % 5) != 4, prev_f);
            prev_f = (k % 5) != 4;
        end

        // Loader drops at count 3, then reasserts: counter restarts, no early override
        drive(1'b0, 16'd0, 1'b0, 16'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'd3, 1'b1, 16'd9, 32'h5A5A_5A5A);
            chk_arb($sformatf("drop_pre%0d", k), 1'b0, 1'b1, k != 0);
        end
        drive(1'b1, 16'd3, 1'b0, 16'd9, 32'h5A5A_5A5A);
        chk("drop_gap.f_gnt", 32'(f_gnt), 32'h1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'd3, 1'b1, 16'd9, 32'h5A5A_5A5A);
            chk_arb($sformatf("drop_re%0d", k), k == 4, k != 4, 1'b1);
        end

        // Reset mid-operation: counter at 3 with a fetch in flight
        drive(1'b0, 16'd0, 1'b0, 16'd0, 32'h0);
        for (int k = 0; k < 3; k++) drive(1'b1, 16'd1, 1'b1, 16'd9, 32'h0);
        chk("midrst.f_gnt_before", 32'(f_gnt), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        f_req = 0; l_req = 0; f_addr = 0; l_addr = 0; l_wdata = 0;
        @(negedge clk);
        chk("midrst.f_rvalid", 32'(f_rvalid), 32'h0);
        chk("midrst.f_rdata",  f_rdata,       32'h0);
        chk("midrst.m_addr",   32'(m_addr),   32'h0);
        chk("midrst.m_we",     32'(m_we),     32'h0);
        chk("midrst.l_gnt",    32'(l_gnt),    32'h0);
        chk("midrst.starved",  32'(starved),  32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst.f_rvalid", 32'(f_rvalid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'd1, 1'b1, 16'd9, 32'h0);
            chk_arb($sformatf("postrst%0d", k), k == 4, k != 4, k != 0);
        end

`ifdef IMEM_BOUNDS_CHECK_EN
        // Out-of-range fetch returns zero data; out-of-range write is granted but dropped
        drive(1'b0, 16'd0, 1'b0, 16'd0, 32'h0);
        drive(1'b1, 16'd64, 1'b0, 16'd0, 32'h0);
        chk("oob.f_gnt", 32'(f_gnt), 32'h1);
        drive(1'b0, 16'd0, 1'b1, 16'd70, 32'h1234_5678);
        chk("oob.f_rvalid", 32'(f_rvalid), 32'h1);
        chk("oob.f_rdata",  f_rdata,       32'h0);
        chk("oob.l_gnt",    32'(l_gnt),    32'h1);
        chk("oob.m_we",     32'(m_we),     32'h0);
`endif

        drive(1'b0, 16'd0, 1'b0, 16'd0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
